piso_load_arbiter: RTL

PISO_LOAD_ARBITER -- requirements
Module: piso_load_arbiter

---
 rtl/piso_load_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/piso_load_arbiter.sv
// Two-requester round-robin arbiter that feeds whole frames of 16-bit words
// into a parallel-in/serial-out serializer, one word per serializer idle slot.
module piso_load_arbiter #(
  parameter int FRAME_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [1:0]  req_valid_i,
  input  logic [15:0] req0_data_i,
  input  logic [15:0] req1_data_i,
  output logic [1:0]  req_ready_o,
  input  logic        piso_busy_i,
  output logic        load_o,
  output logic [15:0] data_o,
  output logic [1:0]  grant_o,
  output logic        frame_done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DRAIN} state_t;

  localparam logic [7:0] LAST_WORD = 8'(FRAME_WORDS);

  state_t      state;
  logic [7:0]  word_cnt;
  logic        rr_ptr;
  logic [1:0]  rr_pick;
  logic [1:0]  accept;
  logic [15:0] accept_data;

  // The preferred requester wins when valid; otherwise the other one may take the frame.
  always_comb begin
    rr_pick = 2'b00;
    if (!rr_ptr)
      rr_pick = req_valid_i[0] ? 2'b01 : (req_valid_i[1] ? 2'b10 : 2'b00);
    else
      rr_pick = req_valid_i[1] ? 2'b10 : (req_valid_i[0] ? 2'b01 : 2'b00);
  end

  // Ready is withheld during reset so nothing is accepted on a reset edge.
  always_comb begin
    req_ready_o = 2'b00;
    if (rst_n) begin
      case (state)
        IDLE:    if (enable_i) req_ready_o = rr_pick;
        DRAIN:   if (!piso_busy_i && word_cnt < LAST_WORD) req_ready_o = grant_o;
        default: req_ready_o = 2'b00;
      endcase
    end
    accept      = req_ready_o & req_valid_i;
    accept_data = accept[1] ? req1_data_i : req0_data_i;
  end

  assign busy_o = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      word_cnt     <= 8'd0;
      rr_ptr       <= 1'b0;
      load_o       <= 1'b0;
      data_o       <= 16'd0;
      grant_o      <= 2'b00;
      frame_done_o <= 1'b0;
    end else begin
      load_o       <= 1'b0;
      frame_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (|accept) begin
            grant_o  <= accept;
            word_cnt <= 8'd1;
            load_o   <= 1'b1;
            data_o   <= accept_data;
            state    <= LOAD;
          end
        end
        LOAD: state <= WAIT;
        // The serializer only raises busy on this edge, so it is not consulted yet.
        WAIT: state <= DRAIN;
        DRAIN: begin
          if (|accept) begin
            word_cnt <= word_cnt + 8'd1;
            load_o   <= 1'b1;
            data_o   <= accept_data;
            state    <= LOAD;
          end else if (!piso_busy_i && word_cnt == LAST_WORD) begin
            frame_done_o <= 1'b1;
            rr_ptr       <= grant_o[0];
            grant_o      <= 2'b00;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
